// File: rtl/umi_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by the arbiter.
// The arbiter uses the slave view; requesters and memory drive the master view.
interface umi_mem_arbiter_if #(
    parameter int N  = 2,
    parameter int AW = 64,
    parameter int DW = 256
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N-1:0]    req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*3-1:0]  req_size;
    logic [N*DW-1:0] req_wrdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [AW-1:0]   mem_addr;
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      mem_size;
    logic [DW-1:0]   mem_wrdata;
    logic [DW-1:0]   mem_rddata;
    logic            mem_ready;
    logic [IW-1:0]   grant_id;

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_size, req_wrdata,
        input  mem_rddata, mem_ready,
        output req_ready, rsp_valid, rsp_data,
        output mem_addr, mem_read, mem_write, mem_size, mem_wrdata, grant_id
    );

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_size, req_wrdata,
        output mem_rddata, mem_ready,
        input  req_ready, rsp_valid, rsp_data,
        input  mem_addr, mem_read, mem_write, mem_size, mem_wrdata, grant_id
    );
endinterface

// File: rtl/umi_mem_arbiter.sv
// Round-robin arbiter sharing one local memory port among N requesters,
// with per-requester lock for atomic sequences and read-data steering.
module umi_mem_arbiter #(
    parameter int N  = 2,
    parameter int AW = 64,
    parameter int DW = 256
) (
    input logic             clk,
    input logic             nreset,
    umi_mem_arbiter_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] rr_ptr;
    logic          lock_q;
    logic [IW-1:0] lock_id;
    logic          hold_q;
    logic [IW-1:0] hold_id;
    logic          rd_pend;
    logic [IW-1:0] rd_id;
    logic [IW-1:0] grant_q;

    logic          win_vld;
    logic [IW-1:0] win_id;
    logic          accept;
    logic [IW-1:0] rr_next;
    int            idx;

    // Winner selection: lock owner first, then a stalled holder, then rotating scan.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        if (lock_q) begin
            if (bus.req_valid[lock_id]) begin
                win_vld = 1'b1;
                win_id  = lock_id;
            end
        end else if (hold_q && bus.req_valid[hold_id]) begin
            win_vld = 1'b1;
            win_id  = hold_id;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                for (int i = 0; i < N; i++) begin
                    if (!win_vld && (i == idx) && bus.req_valid[i]) begin
                        win_vld = 1'b1;
                        win_id  = IW'(i);
                    end
                end
            end
        end
    end

    assign accept  = win_vld & bus.mem_ready;
    assign rr_next = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;

    // Memory-side mux and per-requester accept; all zero when nobody wins.
    always_comb begin
        bus.mem_addr   = '0;
        bus.mem_size   = '0;
        bus.mem_wrdata = '0;
        bus.req_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (win_vld && (win_id == IW'(i))) begin
                bus.mem_addr     = bus.req_addr[i*AW +: AW];
                bus.mem_size     = bus.req_size[i*3 +: 3];
                bus.mem_wrdata   = bus.req_wrdata[i*DW +: DW];
                bus.req_ready[i] = bus.mem_ready;
            end
        end
        bus.mem_write = win_vld &  bus.req_write[win_id];
        bus.mem_read  = win_vld & ~bus.req_write[win_id];
        bus.grant_id  = win_vld ? win_id : grant_q;
    end

    // Read response steering: data passes straight through, valid goes to the issuer.
    always_comb begin
        bus.rsp_data = bus.mem_rddata;
        for (int i = 0; i < N; i++) begin
            bus.rsp_valid[i] = rd_pend && (rd_id == IW'(i));
        end
    end

    // Arbitration state: round-robin pointer, hold on stall, lock, pending read.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rr_ptr  <= '0;
            lock_q  <= 1'b0;
            lock_id <= '0;
            hold_q  <= 1'b0;
            hold_id <= '0;
            rd_pend <= 1'b0;
            rd_id   <= '0;
            grant_q <= '0;
        end else begin
            hold_q  <= win_vld & ~bus.mem_ready;
            rd_pend <= accept & ~bus.req_write[win_id];
            if (win_vld & ~bus.mem_ready) hold_id <= win_id;
            if (win_vld) grant_q <= win_id;
            if (accept) begin
                rr_ptr  <= rr_next;
                lock_q  <= bus.req_lock[win_id];
                lock_id <= win_id;
                rd_id   <= win_id;
            end
        end
    end
endmodule

// File: tb/tb_umi_mem_arbiter.sv
// Directed bench for umi_mem_arbiter: a 2-requester instance with a small
// memory model, plus a 3-requester instance for pointer wrap-around.
module tb_umi_mem_arbiter;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    umi_mem_arbiter_if #(.N(2), .AW(16), .DW(32)) b2 ();
    umi_mem_arbiter_if #(.N(3), .AW(16), .DW(32)) b3 ();

    umi_mem_arbiter #(.N(2), .AW(16), .DW(32)) u2 (.clk(clk), .nreset(nreset), .bus(b2));
    umi_mem_arbiter #(.N(3), .AW(16), .DW(32)) u3 (.clk(clk), .nreset(nreset), .bus(b3));

    // Memory model: unwritten locations read as 0xA0000000 + address.
    logic [31:0]   mem_arr [0:1023];
    logic [1023:0] wr_seen = '0;
    always @(posedge clk) begin
        if (b2.mem_ready && b2.mem_write) begin
            mem_arr[b2.mem_addr[9:0]] <= b2.mem_wrdata;
            wr_seen[b2.mem_addr[9:0]] <= 1'b1;
        end
        if (b2.mem_ready && b2.mem_read)
            b2.mem_rddata <= wr_seen[b2.mem_addr[9:0]] ? mem_arr[b2.mem_addr[9:0]]
                                                        : 32'hA000_0000 + {22'd0, b2.mem_addr[9:0]};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic [1:0] v, input logic [1:0] wr, input logic [1:0] lk,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
        b2.req_valid  = v;
        b2.req_write  = wr;
        b2.req_lock   = lk;
        b2.req_addr   = {a1, a0};
        b2.req_wrdata = {d1, d0};
        #1;
    endtask

    initial begin
        b2.req_valid = '0; b2.req_write = '0; b2.req_lock = '0;
        b2.req_addr = '0; b2.req_wrdata = '0; b2.mem_ready = 1'b1;
        b2.req_size = {3'd5, 3'd2};
        b3.req_valid = '0; b3.req_write = '0; b3.req_lock = '0;
        b3.req_addr = '0; b3.req_wrdata = '0; b3.req_size = '0;
        b3.mem_ready = 1'b1; b3.mem_rddata = '0;

        // Reset state
        #12;
        chk("rst_rsp_valid", 64'(b2.rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(b2.req_ready), 64'd0);
        chk("rst_mem_read",  64'(b2.mem_read),  64'd0);
        chk("rst_mem_write", 64'(b2.mem_write), 64'd0);
        chk("rst_grant",     64'(b2.grant_id),  64'd0);
        chk("rst_grant3",    64'(b3.grant_id),  64'd0);
        nreset = 1'b1;

        // Both requesters reading continuously: grants alternate
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive2(2'b11, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
            chk("rr_grant", 64'(b2.grant_id), 64'(k % 2));
            chk("rr_ready", 64'(b2.req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_read",  64'(b2.mem_read), 64'd1);
            chk("rr_addr",  64'(b2.mem_addr), (k % 2 == 0) ? 64'h100 : 64'h200);
            chk("rr_size",  64'(b2.mem_size), (k % 2 == 0) ? 64'd2 : 64'd5);
            chk("rr_rsp",   64'(b2.rsp_valid), (k == 0) ? 64'd0 : ((k % 2 == 1) ? 64'd1 : 64'd2));
            if (k == 1) chk("rr_data0", 64'(b2.rsp_data), 64'hA000_0100);
            if (k == 2) chk("rr_data1", 64'(b2.rsp_data), 64'hA000_0200);
        end
        cyc();
        drive2(2'b00, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("idle_rsp",   64'(b2.rsp_valid), 64'd1);
        chk("idle_data",  64'(b2.rsp_data), 64'hA000_0100);
        chk("idle_addr",  64'(b2.mem_addr), 64'd0);
        chk("idle_read",  64'(b2.mem_read), 64'd0);
        chk("idle_grant", 64'(b2.grant_id), 64'd0);

        // Stall with mem_ready low: req0 is held although rr_ptr points at req1
        for (int c = 1; c <= 4; c++) begin
            cyc();
            b2.mem_ready = (c == 4);
            drive2((c == 1) ? 2'b01 : 2'b11, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
            chk("hold_grant", 64'(b2.grant_id), 64'd0);
            chk("hold_addr",  64'(b2.mem_addr), 64'h100);
            chk("hold_ready", 64'(b2.req_ready), (c == 4) ? 64'd1 : 64'd0);
        end
        cyc();
        drive2(2'b10, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("hold_next_grant", 64'(b2.grant_id), 64'd1);
        chk("hold_next_ready", 64'(b2.req_ready), 64'd2);
        chk("hold_rsp",        64'(b2.rsp_valid), 64'd1);
        cyc();
        drive2(2'b00, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("hold_rsp1", 64'(b2.rsp_valid), 64'd2);

        // Lock: req1 keeps the port across an idle cycle until an unlocked transfer
        cyc();
        drive2(2'b01, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("lk_pre_grant", 64'(b2.grant_id), 64'd0);
        cyc();
        drive2(2'b11, 2'b10, 2'b10, 16'h100, 16'h300, 32'd0, 32'h11);
        chk("lk1_ready", 64'(b2.req_ready), 64'd2);
        chk("lk1_write", 64'(b2.mem_write), 64'd1);
        chk("lk1_wdata", 64'(b2.mem_wrdata), 64'h11);
        chk("lk1_rsp",   64'(b2.rsp_valid), 64'd1);
        cyc();
        drive2(2'b11, 2'b10, 2'b10, 16'h100, 16'h304, 32'd0, 32'h22);
        chk("lk2_ready", 64'(b2.req_ready), 64'd2);
        cyc();
        drive2(2'b01, 2'b10, 2'b10, 16'h100, 16'h304, 32'd0, 32'h22);
        chk("lk_idle_ready", 64'(b2.req_ready), 64'd0);
        chk("lk_idle_read",  64'(b2.mem_read), 64'd0);
        chk("lk_idle_grant", 64'(b2.grant_id), 64'd1);
        cyc();
        drive2(2'b11, 2'b10, 2'b00, 16'h100, 16'h308, 32'd0, 32'h33);
        chk("lk3_ready", 64'(b2.req_ready), 64'd2);
        cyc();
        drive2(2'b01, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("lk_after_ready", 64'(b2.req_ready), 64'd1);
        chk("lk_after_rsp",   64'(b2.rsp_valid), 64'd0);

        // Reset while locked with a read pending
        cyc();
        drive2(2'b10, 2'b00, 2'b10, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("pre_rst_ready", 64'(b2.req_ready), 64'd2);
        chk("pre_rst_rsp",   64'(b2.rsp_valid), 64'd1);
        cyc();
        nreset = 1'b0;
        drive2(2'b00, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("mid_rst_rsp", 64'(b2.rsp_valid), 64'd0);
        cyc();
        nreset = 1'b1;
        drive2(2'b11, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("post_rst_grant", 64'(b2.grant_id), 64'd0);
        chk("post_rst_ready", 64'(b2.req_ready), 64'd1);
        chk("post_rst_rsp",   64'(b2.rsp_valid), 64'd0);
        cyc();
        drive2(2'b00, 2'b00, 2'b00, 16'h100, 16'h200, 32'd0, 32'd0);
        chk("post_rst_rsp0", 64'(b2.rsp_valid), 64'd1);

        // Write then read of the same address by different requesters
        cyc();
        drive2(2'b01, 2'b01, 2'b00, 16'h40, 16'h40, 32'hDEAD_BEEF, 32'd0);
        chk("wr_write", 64'(b2.mem_write), 64'd1);
        chk("wr_read",  64'(b2.mem_read), 64'd0);
        chk("wr_rsp",   64'(b2.rsp_valid), 64'd0);
        cyc();
        drive2(2'b10, 2'b00, 2'b00, 16'h40, 16'h40, 32'd0, 32'd0);
        chk("rd_read",  64'(b2.mem_read), 64'd1);
        chk("rd_write", 64'(b2.mem_write), 64'd0);
        chk("rd_grant", 64'(b2.grant_id), 64'd1);
        chk("rd_rsp",   64'(b2.rsp_valid), 64'd0);
        cyc();
        drive2(2'b00, 2'b00, 2'b00, 16'h40, 16'h40, 32'd0, 32'd0);
        chk("rd_rsp1",  64'(b2.rsp_valid), 64'd2);
        chk("rd_data",  64'(b2.rsp_data), 64'hDEAD_BEEF);
        cyc();
        #1;
        chk("rd_rsp_end", 64'(b2.rsp_valid), 64'd0);

        // N=3: pointer wraps from 2 back to 0
        cyc();
        b3.req_valid = 3'b100;
        #1;
        chk("n3_grant2", 64'(b3.grant_id), 64'd2);
        chk("n3_ready2", 64'(b3.req_ready), 64'd4);
        cyc();
        b3.req_valid = 3'b101;
        #1;
        chk("n3_wrap_grant", 64'(b3.grant_id), 64'd0);
        chk("n3_wrap_ready", 64'(b3.req_ready), 64'd1);
        chk("n3_rsp",        64'(b3.rsp_valid), 64'd4);
        cyc();
        #1;
        chk("n3_next_grant", 64'(b3.grant_id), 64'd2);
        chk("n3_rsp0",       64'(b3.rsp_valid), 64'd1);
        cyc();
        b3.req_valid = 3'b000;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
